// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM command responder: commands, error codes,
// init FSM states, bank states, CAS-latency mode values and the access record.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_LOADMODE  = 3'b000,
        CMD_REFRESH   = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_ACTIVE    = 3'b011,
        CMD_WRITE     = 3'b100,
        CMD_READ      = 3'b101,
        CMD_BTERM     = 3'b110,
        CMD_NOP       = 3'b111
    } sdram_cmd_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_BAD_INIT  = 3'd1;
    localparam logic [2:0] ERR_BAD_MODE  = 3'd2;
    localparam logic [2:0] ERR_BANK_OPEN = 3'd3;
    localparam logic [2:0] ERR_BANK_IDLE = 3'd4;
    localparam logic [2:0] ERR_TRCD      = 3'd5;
    localparam logic [2:0] ERR_TRP       = 3'd6;
    localparam logic [2:0] ERR_TRFC      = 3'd7;

    typedef enum logic [2:0] {
        ST_WAIT_PRE  = 3'd0,
        ST_WAIT_REF1 = 3'd1,
        ST_WAIT_REF2 = 3'd2,
        ST_WAIT_MODE = 3'd3,
        ST_RUN       = 3'd4
    } init_state_t;

    typedef enum logic {
        BANK_IDLE = 1'b0,
        BANK_OPEN = 1'b1
    } bank_state_t;

    localparam logic [2:0] MODE_CL2 = 3'b010;
    localparam logic [2:0] MODE_CL3 = 3'b011;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [1:0]  bank;
        logic [12:0] row;
        logic [7:0]  col;
        logic [1:0]  be;
    } acc_t;

    // Lowest set bit of the violation vector wins; zero when nothing is set.
    function automatic logic [2:0] first_err(input logic [7:1] vec);
        logic [2:0] code;
        code = ERR_NONE;
        for (int i = 7; i >= 1; i--) begin
            if (vec[i]) begin
                code = 3'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// One bank: IDLE/OPEN state and open row; with SDRAM_RESP_TIMING_CHECK_EN
// it also keeps the tRCD and tRP down-counters.
module sdram_bank_tracker
    import sdram_pkg::*;
`ifdef SDRAM_RESP_TIMING_CHECK_EN
#(
    parameter int TRCD = 2,
    parameter int TRP  = 2
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        act,
    input  logic        pre,
    input  logic        ap,
    input  logic [12:0] row_in,
    output logic        is_open,
    output logic [12:0] row
`ifdef SDRAM_RESP_TIMING_CHECK_EN
    ,
    output logic        rcd_busy,
    output logic        rp_busy
`endif
);

    bank_state_t state_r;

    assign is_open = (state_r == BANK_OPEN);

    // Bank open/close state and the row captured by ACTIVE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= BANK_IDLE;
            row     <= 13'h0000;
        end else if (en) begin
            if (act) begin
                state_r <= BANK_OPEN;
                row     <= row_in;
            end else if (pre || ap) begin
                state_r <= BANK_IDLE;
            end
        end
    end

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(TRP - 1);

    logic [CNT_W-1:0] rcd_cnt_r;
    logic [CNT_W-1:0] rp_cnt_r;
    logic             ap_pend_r;

    assign rcd_busy = (rcd_cnt_r != 8'd0);
    assign rp_busy  = (rp_cnt_r != 8'd0);

    // Auto-precharge starts its tRP window one accepted edge after the command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcd_cnt_r <= 8'd0;
            rp_cnt_r  <= 8'd0;
            ap_pend_r <= 1'b0;
        end else if (en) begin
            ap_pend_r <= ap;
            if (act) begin
                rcd_cnt_r <= RCD_LOAD;
            end else if (rcd_cnt_r != 8'd0) begin
                rcd_cnt_r <= rcd_cnt_r - 8'd1;
            end
            if (pre || ap_pend_r) begin
                rp_cnt_r <= RP_LOAD;
            end else if (rp_cnt_r != 8'd0) begin
                rp_cnt_r <= rp_cnt_r - 8'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/sdram_cmd_responder.sv
// SDRAM command-side responder: init sequencing, bank tracking, read/write
// strobes and sticky violation reporting. Optional timing checks: SDRAM_RESP_TIMING_CHECK_EN.
module sdram_cmd_responder
    import sdram_pkg::*;
#(
    parameter int TRCD = 2,
    parameter int TRP  = 2,
    parameter int TRFC = 7
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        RAS,
    input  logic        CAS,
    input  logic        RAMWE,
    input  logic        CKE,
    input  logic [1:0]  BA,
    input  logic [12:0] MA,
    input  logic [1:0]  DQM,
    output logic        READY,
    output logic        RD_VALID,
    output logic        WR_STB,
    output logic [1:0]  ACC_BANK,
    output logic [12:0] ACC_ROW,
    output logic [7:0]  ACC_COL,
    output logic [1:0]  BYTE_EN,
    output logic        ERR,
    output logic [2:0]  ERR_CODE,
    output logic [15:0] REF_CNT
);

    if (TRCD < 1 || TRP < 1 || TRFC < 1) begin : g_param_check
        $error("sdram_cmd_responder: TRCD, TRP and TRFC must be at least 1");
    end

    sdram_cmd_t  cmd_s;
    init_state_t state_r;
    init_state_t next_state_s;
    logic        cke_r;
    logic        en_s;
    logic        cl3_r;
    logic [3:0]  bank_oh_s;
    logic [3:0]  bank_open_s;
    logic [12:0] bank_row_s [4];
    logic        any_open_s;
    logic        sel_open_s;
    logic        mode_ok_s;
    logic [3:0]  act_s;
    logic [3:0]  pre_s;
    logic [3:0]  ap_s;
    logic        do_read_s;
    logic        do_write_s;
    logic        do_ref_s;
    logic        do_mode_s;
    logic [7:1]  err_vec_s;
    logic [2:0]  rd_v_r;
    acc_t [2:0]  rd_d_r;
    acc_t        cmd_acc_s;

    assign cmd_s      = sdram_cmd_t'({RAS, CAS, RAMWE});
    assign en_s       = cke_r;
    assign bank_oh_s  = 4'(4'b0001 << BA);
    assign any_open_s = |bank_open_s;
    assign sel_open_s = bank_open_s[BA];
    assign mode_ok_s  = ((MA[6:4] == MODE_CL2) || (MA[6:4] == MODE_CL3)) && (MA[2:0] == 3'b000);
    assign cmd_acc_s  = '{bank: BA, row: bank_row_s[BA], col: MA[7:0], be: ~DQM};

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    logic [3:0]       rcd_busy_s;
    logic [3:0]       rp_busy_s;
    logic [CNT_W-1:0] rfc_cnt_r;
`endif

    for (genvar b = 0; b < 4; b++) begin : g_bank
        sdram_bank_tracker
`ifdef SDRAM_RESP_TIMING_CHECK_EN
            #(.TRCD(TRCD), .TRP(TRP))
`endif
            u_bank (
                .clk     (CLK),
                .rst     (RST),
                .en      (en_s),
                .act     (act_s[b]),
                .pre     (pre_s[b]),
                .ap      (ap_s[b]),
                .row_in  (MA),
                .is_open (bank_open_s[b]),
                .row     (bank_row_s[b])
`ifdef SDRAM_RESP_TIMING_CHECK_EN
                ,
                .rcd_busy(rcd_busy_s[b]),
                .rp_busy (rp_busy_s[b])
`endif
            );
    end

    // Command decode against init state and bank state; illegal commands are flagged, not executed
    always_comb begin
        next_state_s = state_r;
        act_s        = 4'b0000;
        pre_s        = 4'b0000;
        ap_s         = 4'b0000;
        do_read_s    = 1'b0;
        do_write_s   = 1'b0;
        do_ref_s     = 1'b0;
        do_mode_s    = 1'b0;
        err_vec_s    = 7'b0000000;
        case (state_r)
            ST_WAIT_PRE: begin
                if (cmd_s == CMD_PRECHARGE && MA[10]) begin
                    pre_s        = 4'b1111;
                    next_state_s = ST_WAIT_REF1;
                end else if (cmd_s != CMD_NOP) begin
                    err_vec_s[ERR_BAD_INIT] = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_WAIT_REF1, ST_WAIT_REF2: begin
                if (cmd_s == CMD_REFRESH) begin
                    do_ref_s     = 1'b1;
                    next_state_s = (state_r == ST_WAIT_REF1) ? ST_WAIT_REF2 : ST_WAIT_MODE;
                end else if (cmd_s != CMD_NOP) begin
                    err_vec_s[ERR_BAD_INIT] = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_WAIT_MODE: begin
                if (cmd_s == CMD_LOADMODE && mode_ok_s) begin
                    do_mode_s    = 1'b1;
                    next_state_s = ST_RUN;
                end else if (cmd_s == CMD_LOADMODE) begin
                    err_vec_s[ERR_BAD_MODE] = 1'b1;
                end else if (cmd_s != CMD_NOP) begin
                    err_vec_s[ERR_BAD_INIT] = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RUN: begin
                case (cmd_s)
                    CMD_LOADMODE: begin
                        if (any_open_s) begin
                            err_vec_s[ERR_BANK_OPEN] = 1'b1;
                        end else if (mode_ok_s) begin
                            do_mode_s = 1'b1;
                        end else begin
                            err_vec_s[ERR_BAD_MODE] = 1'b1;
                        end
                    end
                    CMD_REFRESH: begin
                        if (any_open_s) begin
                            err_vec_s[ERR_BANK_OPEN] = 1'b1;
                        end else begin
                            do_ref_s = 1'b1;
                        end
                    end
                    CMD_PRECHARGE: begin
                        pre_s = MA[10] ? 4'b1111 : bank_oh_s;
                    end
                    CMD_ACTIVE: begin
                        if (sel_open_s) begin
                            err_vec_s[ERR_BANK_OPEN] = 1'b1;
                        end else begin
                            act_s = bank_oh_s;
                        end
                    end
                    CMD_READ, CMD_WRITE: begin
                        if (!sel_open_s) begin
                            err_vec_s[ERR_BANK_IDLE] = 1'b1;
                        end else begin
                            do_read_s  = (cmd_s == CMD_READ);
                            do_write_s = (cmd_s == CMD_WRITE);
                            ap_s       = MA[10] ? bank_oh_s : 4'b0000;
                        end
                    end
                    default: begin
                        act_s = 4'b0000;
                    end
                endcase
            end
            default: begin
                next_state_s = ST_WAIT_PRE;
            end
        endcase
`ifdef SDRAM_RESP_TIMING_CHECK_EN
        if (rfc_cnt_r != 8'd0 && cmd_s != CMD_NOP) begin
            err_vec_s[ERR_TRFC] = 1'b1;
        end else begin
            err_vec_s[ERR_TRFC] = 1'b0;
        end
        if ((do_read_s || do_write_s) && rcd_busy_s[BA]) begin
            err_vec_s[ERR_TRCD] = 1'b1;
        end else begin
            err_vec_s[ERR_TRCD] = 1'b0;
        end
        if ((act_s != 4'b0000) && rp_busy_s[BA]) begin
            err_vec_s[ERR_TRP] = 1'b1;
        end else begin
            err_vec_s[ERR_TRP] = 1'b0;
        end
`endif
    end

    // CKE pipeline, init FSM, CAS latency, refresh count and sticky error
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cke_r    <= 1'b1;
            state_r  <= ST_WAIT_PRE;
            cl3_r    <= 1'b0;
            READY    <= 1'b0;
            REF_CNT  <= 16'h0000;
            ERR      <= 1'b0;
            ERR_CODE <= ERR_NONE;
        end else begin
            cke_r <= CKE;
            if (en_s) begin
                state_r <= next_state_s;
                READY   <= (next_state_s == ST_RUN);
                if (do_mode_s) begin
                    cl3_r <= (MA[6:4] == MODE_CL3);
                end
                if (do_ref_s && REF_CNT != 16'hFFFF) begin
                    REF_CNT <= REF_CNT + 16'd1;
                end
                if (!ERR && err_vec_s != 7'b0000000) begin
                    ERR      <= 1'b1;
                    ERR_CODE <= first_err(err_vec_s);
                end
            end
        end
    end

    // Read token pipeline and access strobes; strobes drop on ignored edges
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_v_r   <= 3'b000;
            rd_d_r   <= '0;
            RD_VALID <= 1'b0;
            WR_STB   <= 1'b0;
            ACC_BANK <= 2'b00;
            ACC_ROW  <= 13'h0000;
            ACC_COL  <= 8'h00;
            BYTE_EN  <= 2'b00;
        end else if (en_s) begin
            rd_v_r   <= {rd_v_r[1:0], do_read_s};
            rd_d_r   <= {rd_d_r[1:0], cmd_acc_s};
            WR_STB   <= do_write_s;
            RD_VALID <= cl3_r ? rd_v_r[2] : rd_v_r[1];
            if (cl3_r ? rd_v_r[2] : rd_v_r[1]) begin
                {ACC_BANK, ACC_ROW, ACC_COL, BYTE_EN} <= cl3_r ? rd_d_r[2] : rd_d_r[1];
            end else if (do_write_s) begin
                {ACC_BANK, ACC_ROW, ACC_COL, BYTE_EN} <= cmd_acc_s;
            end
        end else begin
            RD_VALID <= 1'b0;
            WR_STB   <= 1'b0;
        end
    end

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    // Refresh busy window
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rfc_cnt_r <= 8'd0;
        end else if (en_s) begin
            if (do_ref_s) begin
                rfc_cnt_r <= CNT_W'(TRFC - 1);
            end else if (rfc_cnt_r != 8'd0) begin
                rfc_cnt_r <= rfc_cnt_r - 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed bench for sdram_cmd_responder with hand-computed expectations;
// expectations for the timing test depend on SDRAM_RESP_TIMING_CHECK_EN.
module tb_sdram_cmd_responder;

    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_NOP = 3'b111;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RAS = 1'b1;
    logic        CAS = 1'b1;
    logic        RAMWE = 1'b1;
    logic        CKE = 1'b1;
    logic [1:0]  BA = 2'b00;
    logic [12:0] MA = 13'h0000;
    logic [1:0]  DQM = 2'b00;
    logic        READY;
    logic        RD_VALID;
    logic        WR_STB;
    logic [1:0]  ACC_BANK;
    logic [12:0] ACC_ROW;
    logic [7:0]  ACC_COL;
    logic [1:0]  BYTE_EN;
    logic        ERR;
    logic [2:0]  ERR_CODE;
    logic [15:0] REF_CNT;

    int checks = 0;
    int failures = 0;

    sdram_cmd_responder dut (
        .CLK(CLK), .RST(RST), .RAS(RAS), .CAS(CAS), .RAMWE(RAMWE), .CKE(CKE),
        .BA(BA), .MA(MA), .DQM(DQM), .READY(READY), .RD_VALID(RD_VALID),
        .WR_STB(WR_STB), .ACC_BANK(ACC_BANK), .ACC_ROW(ACC_ROW), .ACC_COL(ACC_COL),
        .BYTE_EN(BYTE_EN), .ERR(ERR), .ERR_CODE(ERR_CODE), .REF_CNT(REF_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one command for one edge, then return to NOP just after the edge
    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] m, input logic [1:0] d);
        {RAS, CAS, RAMWE} = c;
        BA = b;
        MA = m;
        DQM = d;
        @(posedge CLK);
        #1;
        {RAS, CAS, RAMWE} = C_NOP;
        DQM = 2'b00;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            issue(C_NOP, 2'b00, 13'h0000, 2'b00);
        end
    endtask

    task automatic do_init();
        issue(C_PRE, 2'b00, 13'h0400, 2'b00);
        nops(8);
        issue(C_REF, 2'b00, 13'h0000, 2'b00);
        nops(8);
        issue(C_REF, 2'b00, 13'h0000, 2'b00);
        nops(8);
        check_val("ready_before_mode", 32'(READY), 32'd0);
        issue(C_LMR, 2'b00, 13'h0020, 2'b00);
    endtask

    initial begin
        // reset state
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check_val("rst_ready", 32'(READY), 32'd0);
        check_val("rst_rd_valid", 32'(RD_VALID), 32'd0);
        check_val("rst_wr_stb", 32'(WR_STB), 32'd0);
        check_val("rst_err", 32'({ERR, ERR_CODE}), 32'd0);
        check_val("rst_ref_cnt", 32'(REF_CNT), 32'd0);
        check_val("rst_acc", 32'({ACC_BANK, ACC_ROW, ACC_COL, BYTE_EN}), 32'd0);
        RST = 1'b0;

        // standard init
        do_init();
        check_val("init_ready", 32'(READY), 32'd1);
        check_val("init_ref_cnt", 32'(REF_CNT), 32'd2);
        check_val("init_err", 32'(ERR), 32'd0);

        // ACTIVE bank1 row 0x123, READ col 0x45 with auto-precharge, CL=2
        issue(C_ACT, 2'd1, 13'h0123, 2'b00);
        nops(2);
        issue(C_RD, 2'd1, 13'h0445, 2'b00);
        check_val("rd_cl2_edge0", 32'(RD_VALID), 32'd0);
        nops(1);
        check_val("rd_cl2_edge1", 32'(RD_VALID), 32'd0);
        nops(1);
        check_val("rd_cl2_edge2", 32'(RD_VALID), 32'd1);
        check_val("rd_cl2_fields", 32'({ACC_BANK, ACC_ROW, ACC_COL, BYTE_EN}), 32'({2'd1, 13'h0123, 8'h45, 2'b11}));
        nops(1);
        check_val("rd_cl2_pulse_end", 32'(RD_VALID), 32'd0);
        check_val("rd_cl2_hold_row", 32'(ACC_ROW), 32'h0123);
        nops(3);

        // READ then CKE low for three cycles: pulse moves from edge 2 to edge 5
        issue(C_ACT, 2'd2, 13'h00AA, 2'b00);
        nops(3);
        issue(C_RD, 2'd2, 13'h0010, 2'b00);
        CKE = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 4) CKE = 1'b1;
            nops(1);
            check_val($sformatf("cke_rd_edge%0d", i), 32'(RD_VALID), (i == 5) ? 32'd1 : 32'd0);
        end
        check_val("cke_rd_fields", 32'({ACC_BANK, ACC_ROW, ACC_COL}), 32'({2'd2, 13'h00AA, 8'h10}));

        // WRITE with DQM=10 on the still-open bank 2
        issue(C_WR, 2'd2, 13'h0033, 2'b10);
        check_val("wr_stb", 32'(WR_STB), 32'd1);
        check_val("wr_fields", 32'({ACC_BANK, ACC_ROW, ACC_COL, BYTE_EN}), 32'({2'd2, 13'h00AA, 8'h33, 2'b01}));
        nops(1);
        check_val("wr_stb_end", 32'(WR_STB), 32'd0);
        check_val("wr_be_hold", 32'(BYTE_EN), 32'd1);
        issue(C_PRE, 2'd2, 13'h0000, 2'b00);
        nops(4);
        issue(C_REF, 2'd0, 13'h0000, 2'b00);
        check_val("run_ref_cnt", 32'(REF_CNT), 32'd3);
        check_val("run_err_clean", 32'(ERR), 32'd0);
        nops(8);

        // READ one cycle after ACTIVE
        issue(C_ACT, 2'd0, 13'h0010, 2'b00);
        issue(C_RD, 2'd0, 13'h0008, 2'b00);
`ifdef SDRAM_RESP_TIMING_CHECK_EN
        check_val("trcd_err", 32'({ERR, ERR_CODE}), 32'({1'b1, 3'd5}));
`else
        check_val("trcd_err", 32'({ERR, ERR_CODE}), 32'd0);
`endif
        issue(C_PRE, 2'd0, 13'h0400, 2'b00);
        nops(4);

        // reset in the middle of a read pulse
        issue(C_ACT, 2'd3, 13'h0055, 2'b00);
        nops(3);
        issue(C_RD, 2'd3, 13'h0007, 2'b00);
        nops(2);
        check_val("pre_rst_rd_valid", 32'(RD_VALID), 32'd1);
        RST = 1'b1;
        #1;
        check_val("mid_rst_rd_valid", 32'(RD_VALID), 32'd0);
        check_val("mid_rst_state", 32'({READY, ERR, ERR_CODE, REF_CNT}), 32'd0);
        check_val("mid_rst_acc", 32'({ACC_BANK, ACC_ROW, ACC_COL, BYTE_EN}), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nops(1);
            check_val($sformatf("post_rst_no_rd%0d", i), 32'(RD_VALID), 32'd0);
        end

        // READ to an idle bank, then ACTIVE to an open bank: first code kept
        do_init();
        issue(C_RD, 2'd1, 13'h0005, 2'b00);
        check_val("idle_read_err", 32'({ERR, ERR_CODE}), 32'({1'b1, 3'd4}));
        issue(C_ACT, 2'd0, 13'h0001, 2'b00);
        nops(2);
        issue(C_ACT, 2'd0, 13'h0002, 2'b00);
        check_val("first_err_kept", 32'({ERR, ERR_CODE}), 32'({1'b1, 3'd4}));

        // switch to CL=3 with all banks idle, then read
        issue(C_PRE, 2'd0, 13'h0400, 2'b00);
        nops(4);
        issue(C_LMR, 2'd0, 13'h0030, 2'b00);
        issue(C_ACT, 2'd2, 13'h00BB, 2'b00);
        nops(3);
        issue(C_RD, 2'd2, 13'h0022, 2'b00);
        for (int i = 1; i <= 4; i++) begin
            nops(1);
            check_val($sformatf("rd_cl3_edge%0d", i), 32'(RD_VALID), (i == 3) ? 32'd1 : 32'd0);
            if (i == 3) begin
                check_val("rd_cl3_fields", 32'({ACC_ROW, ACC_COL}), 32'({13'h00BB, 8'h22}));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
